// File: rtl/conv_sequencer_if.sv
// Handshake and memory/filter bus between the conv sequencer and its host,
// weight memory and the integrationConv datapath.
interface conv_sequencer_if #(
  parameter int DATA_WIDTH = 16,
  parameter int ADDR_WIDTH = 13
) ();
  logic                  start;
  logic                  skip_load;
  logic                  abort;
  logic                  wt_rd_en;
  logic [ADDR_WIDTH-1:0] wt_addr;
  logic [DATA_WIDTH-1:0] wt_rdata;
  logic                  fw_valid;
  logic [1:0]            fw_layer;
  logic [ADDR_WIDTH-1:0] fw_index;
  logic [DATA_WIDTH-1:0] fw_data;
  logic                  conv_rst;
  logic                  out_capture;
  logic                  busy;
  logic                  done;

  modport master (
    input  start, skip_load, abort, wt_rdata,
    output wt_rd_en, wt_addr, fw_valid, fw_layer, fw_index, fw_data,
           conv_rst, out_capture, busy, done
  );

  modport slave (
    output start, skip_load, abort, wt_rdata,
    input  wt_rd_en, wt_addr, fw_valid, fw_layer, fw_index, fw_data,
           conv_rst, out_capture, busy, done
  );
endinterface

// File: rtl/conv_sequencer.sv
// Sequences one image through integrationConv: stream all filter weights,
// hold the datapath out of reset for a fixed window, then strobe capture.
module conv_sequencer #(
  parameter int DATA_WIDTH = 16,
  parameter int WORDS_C1   = 150,
  parameter int WORDS_C2   = 2400,
  parameter int WORDS_C3   = 4608,
  parameter int RUN_CYCLES = 75050,
  parameter int ADDR_WIDTH = 13
) (
  input logic               clk,
  input logic               reset,
  conv_sequencer_if.master  bus
);

  localparam int TOTAL = WORDS_C1 + WORDS_C2 + WORDS_C3;
  localparam int RUN_W = (RUN_CYCLES > 1) ? $clog2(RUN_CYCLES) : 1;
  localparam logic [ADDR_WIDTH-1:0] LAST_ADDR = ADDR_WIDTH'(TOTAL - 1);
  localparam logic [ADDR_WIDTH-1:0] LAST_C1   = ADDR_WIDTH'(WORDS_C1 - 1);
  localparam logic [ADDR_WIDTH-1:0] LAST_C2   = ADDR_WIDTH'(WORDS_C2 - 1);
  localparam logic [RUN_W-1:0]      LAST_RUN  = RUN_W'(RUN_CYCLES - 1);

  typedef enum logic [2:0] {IDLE, LOAD, FLUSH, RUN, DONE} state_t;

  state_t                state_q, state_d;
  logic [ADDR_WIDTH-1:0] addr_q, addr_d;
  logic [1:0]            layer_q, layer_d;
  logic [ADDR_WIDTH-1:0] idx_q, idx_d;
  logic [RUN_W-1:0]      run_q, run_d;
  logic                  wv_q, wv_d;
  logic [1:0]            wl_q, wl_d;
  logic [ADDR_WIDTH-1:0] wi_q, wi_d;
  logic                  layerEnd;

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_q <= IDLE;
      addr_q  <= '0;
      layer_q <= 2'd0;
      idx_q   <= '0;
      run_q   <= '0;
      wv_q    <= 1'b0;
      wl_q    <= 2'd0;
      wi_q    <= '0;
    end else begin
      state_q <= state_d;
      addr_q  <= addr_d;
      layer_q <= layer_d;
      idx_q   <= idx_d;
      run_q   <= run_d;
      wv_q    <= wv_d;
      wl_q    <= wl_d;
      wi_q    <= wi_d;
    end
  end

  assign layerEnd = ((layer_q == 2'd0) && (idx_q == LAST_C1)) ||
                    ((layer_q == 2'd1) && (idx_q == LAST_C2));

  // Counters rest at zero outside their owning state, so an abort or a
  // state exit needs no separate clearing path.
  always_comb begin
    state_d = state_q;
    addr_d  = '0;
    layer_d = 2'd0;
    idx_d   = '0;
    run_d   = '0;
    wv_d    = 1'b0;
    wl_d    = layer_q;
    wi_d    = idx_q;
    case (state_q)
      IDLE: begin
        if (bus.start) state_d = bus.skip_load ? RUN : LOAD;
      end
      LOAD: begin
        wv_d = 1'b1;
        if (addr_q == LAST_ADDR) begin
          state_d = FLUSH;
        end else begin
          addr_d = addr_q + 1'b1;
          if (layerEnd) begin
            layer_d = layer_q + 2'd1;
          end else begin
            layer_d = layer_q;
            idx_d   = idx_q + 1'b1;
          end
        end
      end
      FLUSH: state_d = RUN;
      RUN: begin
        if (run_q == LAST_RUN) state_d = DONE;
        else run_d = run_q + 1'b1;
      end
      DONE: state_d = IDLE;
      default: state_d = IDLE;
    endcase
    // Abort beats everything, including a coincident terminal count, and
    // drops whatever write was about to enter the delayed stage.
    if (bus.abort && (state_q != IDLE)) begin
      state_d = IDLE;
      addr_d  = '0;
      layer_d = 2'd0;
      idx_d   = '0;
      run_d   = '0;
      wv_d    = 1'b0;
    end
  end

  assign bus.wt_rd_en    = (state_q == LOAD);
  assign bus.wt_addr     = addr_q;
  assign bus.fw_valid    = wv_q;
  assign bus.fw_layer    = wl_q;
  assign bus.fw_index    = wi_q;
  assign bus.fw_data     = wv_q ? bus.wt_rdata : {DATA_WIDTH{1'b0}};
  assign bus.conv_rst    = (state_q != RUN) && (state_q != DONE);
  assign bus.out_capture = (state_q == DONE);
  assign bus.done        = (state_q == DONE);
  assign bus.busy        = (state_q != IDLE);

endmodule

// File: tb/tb_conv_sequencer.sv
// Directed bench for conv_sequencer: a small-parameter instance for cycle
// exact tables and corner cases, plus a default-parameter full-image run.
module tb_conv_sequencer;

  logic clk = 1'b0;
  logic reset;
  int   nVectors = 0;
  int   nMiscompares = 0;

  always #5 clk = ~clk;

  conv_sequencer_if #(.DATA_WIDTH(16), .ADDR_WIDTH(13)) smallBus ();
  conv_sequencer_if #(.DATA_WIDTH(16), .ADDR_WIDTH(13)) dfltBus ();

  conv_sequencer #(
    .DATA_WIDTH(16), .WORDS_C1(3), .WORDS_C2(4), .WORDS_C3(5),
    .RUN_CYCLES(10), .ADDR_WIDTH(13)
  ) smallDut (.clk(clk), .reset(reset), .bus(smallBus));

  conv_sequencer dfltDut (.clk(clk), .reset(reset), .bus(dfltBus));

  // Weight memories: each word holds its own address, one-cycle read latency.
  always @(posedge clk) begin
    if (smallBus.wt_rd_en) smallBus.wt_rdata <= {3'b000, smallBus.wt_addr};
    if (dfltBus.wt_rd_en)  dfltBus.wt_rdata  <= {3'b000, dfltBus.wt_addr};
  end

  typedef struct {
    bit start, skip, abort;
    int rd, addr, fwv, layer, idx, data, rst, cap, busy, done;
  } vec_t;

  vec_t abortTbl[10];
  vec_t skipTbl[24];

  function automatic vec_t mk(bit s, bit k, bit a, int rd, int addr, int fwv,
                              int layer, int idx, int data, int rst, int cap,
                              int busy, int done);
    vec_t v;
    v.start = s; v.skip = k; v.abort = a;
    v.rd = rd; v.addr = addr; v.fwv = fwv; v.layer = layer; v.idx = idx;
    v.data = data; v.rst = rst; v.cap = cap; v.busy = busy; v.done = done;
    return v;
  endfunction

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic check(input string name, input int act, input int exp);
    nVectors++;
    if (act !== exp) begin
      nMiscompares++;
      $display("[TB] FAIL %s: got %0d, want %0d", name, act, exp);
    end
  endtask

  task automatic checkOutput(input vec_t v, input string tag);
    check($sformatf("%s.rd_en", tag), int'(smallBus.wt_rd_en), v.rd);
    if (v.rd != 0) check($sformatf("%s.addr", tag), int'(smallBus.wt_addr), v.addr);
    check($sformatf("%s.fw_valid", tag), int'(smallBus.fw_valid), v.fwv);
    if (v.fwv != 0) begin
      check($sformatf("%s.fw_layer", tag), int'(smallBus.fw_layer), v.layer);
      check($sformatf("%s.fw_index", tag), int'(smallBus.fw_index), v.idx);
      check($sformatf("%s.fw_data", tag), int'(smallBus.fw_data), v.data);
    end
    check($sformatf("%s.conv_rst", tag), int'(smallBus.conv_rst), v.rst);
    check($sformatf("%s.capture", tag), int'(smallBus.out_capture), v.cap);
    check($sformatf("%s.busy", tag), int'(smallBus.busy), v.busy);
    check($sformatf("%s.done", tag), int'(smallBus.done), v.done);
  endtask

  task automatic applyStimulus(input vec_t v);
    smallBus.start     = v.start;
    smallBus.skip_load = v.skip;
    smallBus.abort     = v.abort;
    tick();
  endtask

  initial begin
    vec_t idleV;
    vec_t v;
    int   w, nWr, nRd, nCap, capCycle, doneCycle, badWrites, expL, expI;

    idleV = mk(0,0,0, 0,0,0,0,0,0, 1,0,0,0);

    // Abort mid-LOAD at cycle 5, then a fresh start must reload from address 0.
    abortTbl[0] = mk(1,0,0, 0,0, 0,0,0,0, 1,0,0,0);
    abortTbl[1] = mk(0,0,0, 1,0, 0,0,0,0, 1,0,1,0);
    abortTbl[2] = mk(0,0,0, 1,1, 1,0,0,0, 1,0,1,0);
    abortTbl[3] = mk(0,0,0, 1,2, 1,0,1,1, 1,0,1,0);
    abortTbl[4] = mk(0,0,0, 1,3, 1,0,2,2, 1,0,1,0);
    abortTbl[5] = mk(0,0,1, 1,4, 1,1,0,3, 1,0,1,0);
    abortTbl[6] = mk(1,0,0, 0,0, 0,0,0,0, 1,0,0,0);
    abortTbl[7] = mk(0,0,0, 1,0, 0,0,0,0, 1,0,1,0);
    abortTbl[8] = mk(0,0,1, 1,1, 1,0,0,0, 1,0,1,0);
    abortTbl[9] = idleV;

    // skip_load run with a stray start in RUN, back-to-back restart, then
    // abort coinciding with the terminal run cycle.
    skipTbl[0] = mk(1,1,0, 0,0,0,0,0,0, 1,0,0,0);
    for (int r = 1; r <= 10; r++) skipTbl[r] = mk(0,0,0, 0,0,0,0,0,0, 0,0,1,0);
    skipTbl[5].start = 1'b1;
    skipTbl[11] = mk(0,0,0, 0,0,0,0,0,0, 0,1,1,1);
    skipTbl[12] = mk(1,1,0, 0,0,0,0,0,0, 1,0,0,0);
    for (int r = 13; r <= 22; r++) skipTbl[r] = mk(0,0,0, 0,0,0,0,0,0, 0,0,1,0);
    skipTbl[22].abort = 1'b1;
    skipTbl[23] = idleV;

    reset = 1'b0;
    smallBus.start = 1'b0; smallBus.skip_load = 1'b0; smallBus.abort = 1'b0;
    dfltBus.start  = 1'b0; dfltBus.skip_load  = 1'b0; dfltBus.abort  = 1'b0;
    repeat (2) @(posedge clk);
    #1;
    checkOutput(idleV, "reset");
    reset = 1'b1;
    tick();

    for (int k = 0; k < 10; k++) begin
      checkOutput(abortTbl[k], $sformatf("abort[%0d]", k));
      applyStimulus(abortTbl[k]);
    end

    // Full small load: 12 words, layer sizes 3/4/5, DONE at cycle 24.
    checkOutput(idleV, "load[0]");
    smallBus.start = 1'b1;
    for (int c = 1; c <= 25; c++) begin
      tick();
      smallBus.start = 1'b0;
      v = idleV;
      v.rd   = (c >= 1 && c <= 12) ? 1 : 0;
      v.addr = c - 1;
      v.fwv  = (c >= 2 && c <= 13) ? 1 : 0;
      w = c - 2;
      v.layer = (w < 3) ? 0 : (w < 7) ? 1 : 2;
      v.idx   = (w < 3) ? w : (w < 7) ? w - 3 : w - 7;
      v.data  = w;
      v.rst   = (c >= 14 && c <= 24) ? 0 : 1;
      v.cap   = (c == 24) ? 1 : 0;
      v.done  = v.cap;
      v.busy  = (c >= 1 && c <= 24) ? 1 : 0;
      checkOutput(v, $sformatf("load[%0d]", c));
    end

    for (int k = 0; k < 24; k++) begin
      checkOutput(skipTbl[k], $sformatf("skip[%0d]", k));
      applyStimulus(skipTbl[k]);
    end

    // Async reset between edges in the middle of RUN.
    smallBus.start = 1'b1; smallBus.skip_load = 1'b1;
    tick();
    smallBus.start = 1'b0; smallBus.skip_load = 1'b0;
    repeat (3) tick();
    check("arst.pre_busy", int'(smallBus.busy), 1);
    #2;
    reset = 1'b0;
    #1;
    checkOutput(idleV, "arst.now");
    @(posedge clk);
    #1;
    reset = 1'b1;
    tick();
    checkOutput(idleV, "arst.after");

    // Default parameters: one full image.
    nWr = 0; nRd = 0; nCap = 0; capCycle = -1; doneCycle = -1; badWrites = 0;
    dfltBus.start = 1'b1;
    tick();
    dfltBus.start = 1'b0;
    for (int c = 1; c <= 90000; c++) begin
      if (dfltBus.fw_valid) begin
        expL = (nWr < 150) ? 0 : (nWr < 2550) ? 1 : 2;
        expI = (nWr < 150) ? nWr : (nWr < 2550) ? nWr - 150 : nWr - 2550;
        if (int'(dfltBus.fw_layer) != expL || int'(dfltBus.fw_index) != expI ||
            int'(dfltBus.fw_data) != nWr)
          badWrites++;
        nWr++;
      end
      if (dfltBus.wt_rd_en) nRd++;
      if (dfltBus.out_capture) begin
        nCap++;
        capCycle = c;
      end
      if (dfltBus.done) begin
        doneCycle = c;
        break;
      end
      tick();
    end
    check("dflt.writes", nWr, 7158);
    check("dflt.reads", nRd, 7158);
    check("dflt.bad_writes", badWrites, 0);
    check("dflt.done_cycle", doneCycle, 82210);
    check("dflt.capture_cycle", capCycle, 82210);
    check("dflt.capture_count", nCap, 1);
    tick();
    check("dflt.after_done", int'(dfltBus.done), 0);
    check("dflt.after_busy", int'(dfltBus.busy), 0);
    check("dflt.after_rst", int'(dfltBus.conv_rst), 1);

    $display("== %0d vectors applied, %0d miscompares ==", nVectors, nMiscompares);
    $finish;
  end

endmodule
